// File: rtl/fetch_decode_front.sv
// Fetch/decode front end: PC, program memory, IF/ID register, decoder and register files.
// Optional macro RF_BYPASS_EN: register reads return same-cycle writeback data.
module fetch_decode_front #(
  parameter int REGI_BITS  = 4,
  parameter int VECT_BITS  = 2,
  parameter int MEMO_LINES = 64,
  parameter int REGI_SIZE  = 16,
  parameter int VECT_SIZE  = 8,
  parameter int ELEM_SIZE  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             imem_we_i,
  input  logic [$clog2(MEMO_LINES)-1:0]    imem_addr_i,
  input  logic [REGI_SIZE-1:0]             imem_wd_i,
  input  logic                             jump_en_i,
  input  logic [9:0]                       jump_addr_i,
  input  logic                             int_we_i,
  input  logic [REGI_BITS-1:0]             int_dest_i,
  input  logic [REGI_SIZE-1:0]             int_wd_i,
  input  logic                             vec_we_i,
  input  logic [VECT_BITS-1:0]             vec_dest_i,
  input  logic [VECT_SIZE*ELEM_SIZE-1:0]   vec_wd_i,
  input  logic [3:0]                       alu_flags_i,
  output logic [REGI_SIZE-1:0]             pc_o,
  output logic [REGI_SIZE-1:0]             instr_o,
  output logic [REGI_SIZE-1:0]             int_oper1_o,
  output logic [REGI_SIZE-1:0]             int_oper2_o,
  output logic [VECT_SIZE*ELEM_SIZE-1:0]   vec_oper1_o,
  output logic [VECT_SIZE*ELEM_SIZE-1:0]   vec_oper2_o,
  output logic [7:0]                       imm_o,
  output logic [REGI_BITS-1:0]             int_dest_o,
  output logic [VECT_BITS-1:0]             vec_dest_o,
  output logic [2:0]                       alu_op_o,
  output logic [1:0]                       cond_o,
  output logic [9:0]                       jump_addr_o,
  output logic [2:0]                       swap_src_o,
  output logic [2:0]                       swap_dst_o,
  output logic                             en_alu_int_o,
  output logic                             en_alu_v_o,
  output logic                             en_mem_o,
  output logic                             en_jump_o,
  output logic                             en_swap_o,
  output logic                             flag_imm_o,
  output logic                             mem_rd_o,
  output logic                             mem_wr_o,
  output logic                             wr_int_o,
  output logic                             wr_vec_o,
  output logic                             flag_end_o,
  output logic                             flag_nop_o,
  output logic [3:0]                       alu_flags_o
);

  localparam int VW       = VECT_SIZE * ELEM_SIZE;
  localparam int MEM_BITS = $clog2(MEMO_LINES);

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_VADD = 4'h6;
  localparam logic [3:0] OP_VXOR = 4'h7;
  localparam logic [3:0] OP_LDV  = 4'h8;
  localparam logic [3:0] OP_STV  = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_SWAP = 4'hB;
  localparam logic [3:0] OP_END  = 4'hF;

  logic [REGI_SIZE-1:0] pc;
  logic [REGI_SIZE-1:0] ifId;
  logic [REGI_SIZE-1:0] imem [MEMO_LINES];
  logic [REGI_SIZE-1:0] fetched;
  logic                 halted;
  logic [3:0]           opcode;
  logic [3:0]           rdField;
  logic [3:0]           rs1Field;
  logic [3:0]           rs2Field;

  assign fetched  = imem[pc[MEM_BITS-1:0]];
  assign opcode   = ifId[15:12];
  assign rdField  = ifId[11:8];
  assign rs1Field = ifId[7:4];
  assign rs2Field = ifId[3:0];
  assign halted   = (opcode == OP_END);

  // A redirect beats the halt: it is the only way out of an END.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc   <= '0;
      ifId <= '0;
    end else if (jump_en_i) begin
      pc   <= {{(REGI_SIZE-10){1'b0}}, jump_addr_i};
      ifId <= '0;
    end else if (!halted) begin
      pc   <= pc + 1'b1;
      ifId <= fetched;
    end
  end

  // Program memory survives reset so a loaded program can be rerun.
  always_ff @(posedge clk_i) begin
    if (imem_we_i) imem[imem_addr_i] <= imem_wd_i;
  end

  logic [REGI_SIZE-1:0] intRegs [2**REGI_BITS];
  logic [VW-1:0]        vecRegs [2**VECT_BITS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**REGI_BITS; i++) intRegs[i] <= '0;
    end else if (int_we_i) begin
      intRegs[int_dest_i] <= int_wd_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2**VECT_BITS; i++) vecRegs[i] <= '0;
    end else if (vec_we_i) begin
      vecRegs[vec_dest_i] <= vec_wd_i;
    end
  end

  logic [REGI_BITS-1:0] intIdx1;
  logic [REGI_BITS-1:0] intIdx2;
  logic [VECT_BITS-1:0] vecIdx1;
  logic [VECT_BITS-1:0] vecIdx2;

  // ADDI accumulates into rd, so its first operand comes from rd.
  assign intIdx1 = (opcode == OP_ADDI) ? rdField[REGI_BITS-1:0] : rs1Field[REGI_BITS-1:0];
  assign intIdx2 = rs2Field[REGI_BITS-1:0];
  assign vecIdx1 = rdField[VECT_BITS-1:0];
  assign vecIdx2 = rs1Field[VECT_BITS-1:0];

`ifdef RF_BYPASS_EN
  assign int_oper1_o = (int_we_i && int_dest_i == intIdx1) ? int_wd_i : intRegs[intIdx1];
  assign int_oper2_o = (int_we_i && int_dest_i == intIdx2) ? int_wd_i : intRegs[intIdx2];
  assign vec_oper1_o = (vec_we_i && vec_dest_i == vecIdx1) ? vec_wd_i : vecRegs[vecIdx1];
  assign vec_oper2_o = (vec_we_i && vec_dest_i == vecIdx2) ? vec_wd_i : vecRegs[vecIdx2];
`else
  assign int_oper1_o = intRegs[intIdx1];
  assign int_oper2_o = intRegs[intIdx2];
  assign vec_oper1_o = vecRegs[vecIdx1];
  assign vec_oper2_o = vecRegs[vecIdx2];
`endif

  assign pc_o        = pc;
  assign instr_o     = ifId;
  assign imm_o       = ifId[7:0];
  assign int_dest_o  = rdField[REGI_BITS-1:0];
  assign vec_dest_o  = rdField[VECT_BITS-1:0];
  assign cond_o      = ifId[11:10];
  assign jump_addr_o = ifId[9:0];
  assign swap_src_o  = ifId[7:5];
  assign swap_dst_o  = ifId[4:2];
  assign alu_flags_o = alu_flags_i;

  always_comb begin
    alu_op_o     = 3'd0;
    en_alu_int_o = 1'b0;
    en_alu_v_o   = 1'b0;
    en_mem_o     = 1'b0;
    en_jump_o    = 1'b0;
    en_swap_o    = 1'b0;
    flag_imm_o   = 1'b0;
    mem_rd_o     = 1'b0;
    mem_wr_o     = 1'b0;
    wr_int_o     = 1'b0;
    wr_vec_o     = 1'b0;
    flag_end_o   = 1'b0;
    flag_nop_o   = 1'b0;
    case (opcode)
      OP_ADD:  begin en_alu_int_o = 1'b1; wr_int_o = 1'b1; alu_op_o = 3'd0; end
      OP_SUB:  begin en_alu_int_o = 1'b1; wr_int_o = 1'b1; alu_op_o = 3'd1; end
      OP_AND:  begin en_alu_int_o = 1'b1; wr_int_o = 1'b1; alu_op_o = 3'd2; end
      OP_XOR:  begin en_alu_int_o = 1'b1; wr_int_o = 1'b1; alu_op_o = 3'd3; end
      OP_ADDI: begin en_alu_int_o = 1'b1; wr_int_o = 1'b1; flag_imm_o = 1'b1; end
      OP_VADD: begin en_alu_v_o = 1'b1; wr_vec_o = 1'b1; alu_op_o = 3'd0; end
      OP_VXOR: begin en_alu_v_o = 1'b1; wr_vec_o = 1'b1; alu_op_o = 3'd3; end
      OP_LDV:  begin en_mem_o = 1'b1; mem_rd_o = 1'b1; wr_vec_o = 1'b1; end
      OP_STV:  begin en_mem_o = 1'b1; mem_wr_o = 1'b1; end
      OP_JMP:  en_jump_o = 1'b1;
      OP_SWAP: begin en_swap_o = 1'b1; en_alu_v_o = 1'b1; wr_vec_o = 1'b1; alu_op_o = 3'd4; end
      OP_END:  flag_end_o = 1'b1;
      OP_NOP:  flag_nop_o = 1'b1;
      default: flag_nop_o = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fetch_decode_front.sv
// Self-checking bench for fetch_decode_front: directed scenarios plus a randomized run
// against a cycle-level behavioural model of the front end.
module tb_fetch_decode_front;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        imem_we_i = 1'b0;
  logic [5:0]  imem_addr_i = '0;
  logic [15:0] imem_wd_i = '0;
  logic        jump_en_i = 1'b0;
  logic [9:0]  jump_addr_i = '0;
  logic        int_we_i = 1'b0;
  logic [3:0]  int_dest_i = '0;
  logic [15:0] int_wd_i = '0;
  logic        vec_we_i = 1'b0;
  logic [1:0]  vec_dest_i = '0;
  logic [63:0] vec_wd_i = '0;
  logic [3:0]  alu_flags_i = '0;

  logic [15:0] pc_o, instr_o, int_oper1_o, int_oper2_o;
  logic [63:0] vec_oper1_o, vec_oper2_o;
  logic [7:0]  imm_o;
  logic [3:0]  int_dest_o;
  logic [1:0]  vec_dest_o;
  logic [2:0]  alu_op_o, swap_src_o, swap_dst_o;
  logic [1:0]  cond_o;
  logic [9:0]  jump_addr_o;
  logic en_alu_int_o, en_alu_v_o, en_mem_o, en_jump_o, en_swap_o, flag_imm_o;
  logic mem_rd_o, mem_wr_o, wr_int_o, wr_vec_o, flag_end_o, flag_nop_o;
  logic [3:0]  alu_flags_o;

  int checks = 0;
  int errors = 0;

  fetch_decode_front dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_we_i(imem_we_i), .imem_addr_i(imem_addr_i), .imem_wd_i(imem_wd_i),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .int_we_i(int_we_i), .int_dest_i(int_dest_i), .int_wd_i(int_wd_i),
    .vec_we_i(vec_we_i), .vec_dest_i(vec_dest_i), .vec_wd_i(vec_wd_i),
    .alu_flags_i(alu_flags_i),
    .pc_o(pc_o), .instr_o(instr_o),
    .int_oper1_o(int_oper1_o), .int_oper2_o(int_oper2_o),
    .vec_oper1_o(vec_oper1_o), .vec_oper2_o(vec_oper2_o),
    .imm_o(imm_o), .int_dest_o(int_dest_o), .vec_dest_o(vec_dest_o),
    .alu_op_o(alu_op_o), .cond_o(cond_o), .jump_addr_o(jump_addr_o),
    .swap_src_o(swap_src_o), .swap_dst_o(swap_dst_o),
    .en_alu_int_o(en_alu_int_o), .en_alu_v_o(en_alu_v_o), .en_mem_o(en_mem_o),
    .en_jump_o(en_jump_o), .en_swap_o(en_swap_o), .flag_imm_o(flag_imm_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .wr_int_o(wr_int_o), .wr_vec_o(wr_vec_o),
    .flag_end_o(flag_end_o), .flag_nop_o(flag_nop_o), .alu_flags_o(alu_flags_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  // behavioural model state
  logic [15:0] mPc, mIr;
  logic [15:0] mMem [64];
  logic [15:0] mInt [16];
  logic [63:0] mVec [4];

  typedef struct packed {
    logic aluInt, aluV, mem, jump, swap, imm, memRd, memWr, wrInt, wrVec, fend, fnop;
    logic [2:0] aluOp;
  } ctrl_t;

  // Reference decode written from the opcode table, grouped by instruction class.
  function automatic ctrl_t refDecode(input logic [15:0] ins);
    ctrl_t c;
    int op;
    c = '0;
    op = int'(ins[15:12]);
    if (op >= 1 && op <= 4) begin
      c.aluInt = 1; c.wrInt = 1; c.aluOp = 3'(op - 1);
    end else if (op == 5) begin
      c.aluInt = 1; c.wrInt = 1; c.imm = 1;
    end else if (op == 6 || op == 7) begin
      c.aluV = 1; c.wrVec = 1; c.aluOp = (op == 6) ? 3'd0 : 3'd3;
    end else if (op == 8) begin
      c.mem = 1; c.memRd = 1; c.wrVec = 1;
    end else if (op == 9) begin
      c.mem = 1; c.memWr = 1;
    end else if (op == 10) begin
      c.jump = 1;
    end else if (op == 11) begin
      c.swap = 1; c.aluV = 1; c.wrVec = 1; c.aluOp = 3'd4;
    end else if (op == 15) begin
      c.fend = 1;
    end else begin
      c.fnop = 1;
    end
    return c;
  endfunction

  function automatic logic [15:0] intRead(input int idx);
`ifdef RF_BYPASS_EN
    if (int_we_i && int'(int_dest_i) == idx) return int_wd_i;
`endif
    return mInt[idx];
  endfunction

  function automatic logic [63:0] vecRead(input int idx);
`ifdef RF_BYPASS_EN
    if (vec_we_i && int'(vec_dest_i) == idx) return vec_wd_i;
`endif
    return mVec[idx];
  endfunction

  // driver: advance one clock, updating the model from the inputs seen at the edge
  task automatic tick();
    logic [15:0] nPc, nIr;
    if (!rst_ni) begin
      nPc = 16'h0; nIr = 16'h0;
    end else if (jump_en_i) begin
      nPc = {6'b0, jump_addr_i}; nIr = 16'h0;
    end else if (mIr[15:12] == 4'hF) begin
      nPc = mPc; nIr = mIr;
    end else begin
      nPc = mPc + 16'd1; nIr = mMem[mPc % 64];
    end
    @(posedge clk_i);
    mPc = nPc;
    mIr = nIr;
    if (imem_we_i) mMem[imem_addr_i] = imem_wd_i;
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) mInt[i] = '0;
      for (int i = 0; i < 4; i++) mVec[i] = '0;
    end else begin
      if (int_we_i) mInt[int_dest_i] = int_wd_i;
      if (vec_we_i) mVec[vec_dest_i] = vec_wd_i;
    end
    #1;
    imem_we_i = 0; jump_en_i = 0; int_we_i = 0; vec_we_i = 0;
  endtask

  task automatic loadWord(input logic [5:0] a, input logic [15:0] d);
    imem_we_i = 1; imem_addr_i = a; imem_wd_i = d;
    tick();
  endtask

  task automatic writeInt(input logic [3:0] idx, input logic [15:0] d);
    int_we_i = 1; int_dest_i = idx; int_wd_i = d;
    tick();
  endtask

  task automatic jumpTo(input logic [9:0] a);
    jump_en_i = 1; jump_addr_i = a;
    tick();
  endtask

  task automatic test_reset();
    rst_ni = 0;
    #1;
    for (int a = 0; a < 64; a++) loadWord(6'(a), 16'h0000);
    checks++; if (pc_o !== 16'h0) begin errors++; $display("FAIL reset_pc got %h want 0000", pc_o); end
    checks++; if (instr_o !== 16'h0) begin errors++; $display("FAIL reset_instr got %h want 0000", instr_o); end
    checks++; if (flag_nop_o !== 1'b1) begin errors++; $display("FAIL reset_nop got %b want 1", flag_nop_o); end
    checks++; if (int_oper1_o !== 16'h0 || vec_oper1_o !== 64'h0) begin
      errors++; $display("FAIL reset_operands got %h/%h want 0", int_oper1_o, vec_oper1_o);
    end
    rst_ni = 1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (pc_o !== 16'(k)) begin errors++; $display("FAIL reset_count got %h want %h", pc_o, 16'(k)); end
    end
  endtask

  task automatic test_int_alu();
    loadWord(6'd0, 16'h1123);
    writeInt(4'd2, 16'd5);
    writeInt(4'd3, 16'd7);
    jumpTo(10'd0);
    tick();
    checks++; if (instr_o !== 16'h1123) begin errors++; $display("FAIL alu_instr got %h want 1123", instr_o); end
    checks++; if ({en_alu_int_o, wr_int_o, alu_op_o, int_dest_o} !== {1'b1, 1'b1, 3'd0, 4'd1}) begin
      errors++; $display("FAIL alu_ctrl got %b%b %0d %0d want 11 0 1", en_alu_int_o, wr_int_o, alu_op_o, int_dest_o);
    end
    checks++; if (int_oper1_o !== 16'd5 || int_oper2_o !== 16'd7) begin
      errors++; $display("FAIL alu_operands got %0d/%0d want 5/7", int_oper1_o, int_oper2_o);
    end
  endtask

  task automatic test_swap();
    vec_we_i = 1; vec_dest_i = 2'd1; vec_wd_i = 64'h0102030405060708;
    tick();
    loadWord(6'd8, 16'hB1A4);
    jumpTo(10'd8);
    tick();
    checks++; if (en_swap_o !== 1'b1 || en_alu_v_o !== 1'b1 || alu_op_o !== 3'd4) begin
      errors++; $display("FAIL swap_ctrl got %b%b %0d want 11 4", en_swap_o, en_alu_v_o, alu_op_o);
    end
    checks++; if (vec_oper1_o !== 64'h0102030405060708) begin
      errors++; $display("FAIL swap_oper got %h want 0102030405060708", vec_oper1_o);
    end
    checks++; if ({swap_src_o, swap_dst_o, vec_dest_o} !== {3'd5, 3'd1, 2'd1}) begin
      errors++; $display("FAIL swap_fields got %0d %0d %0d want 5 1 1", swap_src_o, swap_dst_o, vec_dest_o);
    end
  endtask

  task automatic test_jump();
    loadWord(6'h20, 16'hA5FF);
    jumpTo(10'h020);
    checks++; if (pc_o !== 16'h0020 || instr_o !== 16'h0) begin
      errors++; $display("FAIL jump_redirect got pc %h instr %h want 0020 0000", pc_o, instr_o);
    end
    tick();
    checks++; if (en_jump_o !== 1'b1 || cond_o !== 2'd1 || jump_addr_o !== 10'h1FF || flag_nop_o !== 1'b0) begin
      errors++; $display("FAIL jump_decode got %b %0d %h nop %b want 1 1 1ff 0", en_jump_o, cond_o, jump_addr_o, flag_nop_o);
    end
  endtask

  task automatic test_halt();
    loadWord(6'd3, 16'hF000);
    jumpTo(10'd0);
    for (int k = 0; k < 4; k++) tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (pc_o !== 16'd4 || flag_end_o !== 1'b1) begin
        errors++; $display("FAIL halt_hold got pc %h end %b want 0004 1", pc_o, flag_end_o);
      end
    end
    jumpTo(10'd0);
    loadWord(6'd3, 16'h0000);
    checks++; if (pc_o !== 16'd1 || flag_end_o !== 1'b0) begin
      errors++; $display("FAIL halt_resume got pc %h end %b want 0001 0", pc_o, flag_end_o);
    end
  endtask

  task automatic test_bypass();
    logic [15:0] want;
    jumpTo(10'd0);
    tick();
`ifdef RF_BYPASS_EN
    want = 16'h1234;
`else
    want = 16'd5;
`endif
    int_we_i = 1; int_dest_i = 4'd2; int_wd_i = 16'h1234;
    #1;
    checks++; if (int_oper1_o !== want) begin errors++; $display("FAIL bypass_oper got %h want %h", int_oper1_o, want); end
    tick();
    checks++; if (int_oper1_o !== 16'h1234 && instr_o === 16'h1123) begin
      errors++; $display("FAIL bypass_after got %h want 1234", int_oper1_o);
    end
  endtask

  task automatic test_random();
    ctrl_t expC, obsC;
    logic [15:0] ins;
    for (int n = 0; n < 400; n++) begin
      imem_we_i = ($urandom_range(0, 3) == 0);
      imem_addr_i = 6'($urandom_range(0, 63));
      imem_wd_i = 16'($urandom);
      jump_en_i = ($urandom_range(0, 7) == 0);
      jump_addr_i = 10'($urandom_range(0, 80));
      int_we_i = $urandom_range(0, 1) == 1;
      int_dest_i = 4'($urandom);
      int_wd_i = 16'($urandom);
      vec_we_i = $urandom_range(0, 1) == 1;
      vec_dest_i = 2'($urandom);
      vec_wd_i = {$urandom, $urandom};
      alu_flags_i = 4'($urandom);
      #1;
      ins = mIr;
      expC = refDecode(ins);
      obsC = {en_alu_int_o, en_alu_v_o, en_mem_o, en_jump_o, en_swap_o, flag_imm_o,
              mem_rd_o, mem_wr_o, wr_int_o, wr_vec_o, flag_end_o, flag_nop_o, alu_op_o};
      checks++; if (pc_o !== mPc || instr_o !== ins) begin
        errors++; $display("FAIL rand_fetch got %h/%h want %h/%h", pc_o, instr_o, mPc, ins);
      end
      checks++; if (obsC !== expC) begin errors++; $display("FAIL rand_ctrl got %h want %h", obsC, expC); end
      checks++; if (int_oper1_o !== intRead((ins[15:12] == 4'h5) ? int'(ins[11:8]) : int'(ins[7:4])) ||
                    int_oper2_o !== intRead(int'(ins[3:0]))) begin
        errors++; $display("FAIL rand_int_oper got %h/%h", int_oper1_o, int_oper2_o);
      end
      checks++; if (vec_oper1_o !== vecRead(int'(ins[9:8])) || vec_oper2_o !== vecRead(int'(ins[5:4]))) begin
        errors++; $display("FAIL rand_vec_oper got %h/%h", vec_oper1_o, vec_oper2_o);
      end
      checks++; if ({imm_o, int_dest_o, vec_dest_o, cond_o, jump_addr_o, swap_src_o, swap_dst_o, alu_flags_o} !==
                    {ins[7:0], ins[11:8], ins[9:8], ins[11:10], ins[9:0], ins[7:5], ins[4:2], alu_flags_i}) begin
        errors++; $display("FAIL rand_fields instr %h imm %h rd %h flags %h", ins, imm_o, int_dest_o, alu_flags_o);
      end
      tick();
    end
  endtask

  initial begin
    mPc = '0; mIr = '0;
    for (int i = 0; i < 64; i++) mMem[i] = '0;
    for (int i = 0; i < 16; i++) mInt[i] = '0;
    for (int i = 0; i < 4; i++) mVec[i] = '0;
    test_reset();
    test_int_alu();
    test_swap();
    test_jump();
    test_halt();
    test_bypass();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode_front.md
Name: fetch_decode_front

Overview:
- Front end of the 4-stage SIMD encryption core: PC register, instruction memory, IF/ID pipeline register and instruction decoder with integer and vector register files.
- Produces decoded control, operands and register destinations for the execute stage.
- Accepts writeback from the memory stage and jump redirects.

Parameters:
- REGI_BITS, 4, integer register index width (16 registers).
- VECT_BITS, 2, vector register index width (4 registers).
- MEMO_LINES, 64, instruction memory depth (16-bit words).
- REGI_SIZE, 16, integer register, PC and instruction width.
- VECT_SIZE, 8, lanes per vector.
- ELEM_SIZE, 8, bits per lane; vector width VW = VECT_SIZE*ELEM_SIZE = 64.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- imem_we_i  in  1  instruction memory write enable (program load).
- imem_addr_i  in  6  program load address.
- imem_wd_i  in  16  program load data.
- jump_en_i  in  1  PC redirect request.
- jump_addr_i  in  10  redirect target, zero-extended to 16 bits.
- int_we_i  in  1  integer writeback enable.
- int_dest_i  in  REGI_BITS  integer writeback index.
- int_wd_i  in  16  integer writeback data.
- vec_we_i  in  1  vector writeback enable.
- vec_dest_i  in  VECT_BITS  vector writeback index.
- vec_wd_i  in  VW  vector writeback data.
- alu_flags_i  in  4  flags from execute; passed through.
- pc_o  out  16  current PC.
- instr_o  out  16  instruction held in IF/ID.
- int_oper1_o, int_oper2_o  out  16  integer operands R[rs1], R[rs2].
- vec_oper1_o, vec_oper2_o  out  VW  vector operands V[rd[1:0]], V[rs1[1:0]].
- imm_o  out  8  instr[7:0].
- int_dest_o  out  REGI_BITS  instr[11:8].
- vec_dest_o  out  VECT_BITS  instr[9:8].
- alu_op_o  out  3  ALU operation.
- cond_o  out  2  jump condition, instr[11:10].
- jump_addr_o  out  10  instr[9:0].
- swap_src_o, swap_dst_o  out  3  instr[7:5], instr[4:2].
- en_alu_int_o, en_alu_v_o, en_mem_o, en_jump_o, en_swap_o, flag_imm_o, mem_rd_o, mem_wr_o, wr_int_o, wr_vec_o, flag_end_o, flag_nop_o  out  1  decoded controls.
- alu_flags_o  out  4  equals alu_flags_i, combinational.

Behaviour:
- Instruction fields: op = instr[15:12], rd = [11:8], rs1 = [7:4], rs2 = [3:0].
- Opcode decode (all other controls 0):
  - 0x0 NOP: flag_nop.
  - 0x1 ADD, 0x2 SUB, 0x3 AND, 0x4 XOR: en_alu_int, wr_int; alu_op = 0, 1, 2, 3.
  - 0x5 ADDI: en_alu_int, wr_int, flag_imm, alu_op = 0; int_oper1 reads R[rd].
  - 0x6 VADD, 0x7 VXOR: en_alu_v, wr_vec; alu_op = 0, 3.
  - 0x8 LDV: en_mem, mem_rd, wr_vec. 0x9 STV: en_mem, mem_wr. Address is int_oper1.
  - 0xA JMP: en_jump.
  - 0xB SWAP: en_swap, en_alu_v, wr_vec, alu_op = 4.
  - 0xF END: flag_end.
  - Undefined opcodes (0xC–0xE) decode as NOP: flag_nop = 1.
- Fetch:
  - Instruction memory reads asynchronously at pc[5:0].
  - Each cycle the PC loads: jump target if jump_en_i; else holds if the IF/ID instruction is END (halt); else pc+1.
  - jump_en_i has priority over halt.
  - PC wraps 0xFFFF -> 0; memory address uses pc modulo 64.
- IF/ID register captures the fetched instruction each cycle.
  - When jump_en_i = 1 it captures 0x0000 (flush to NOP).
  - When halted it holds its value.
- Program memory write is synchronous and independent of reset.
  - Reading an address in the cycle it is written returns the old data.
- Register files:
  - Synchronous write, asynchronous read.
  - Integer and vector writes may occur in the same cycle.
- Reset (asynchronous, rst_ni = 0):
  - PC = 0, IF/ID = 0x0000, so all outputs decode NOP with operands 0.
  - All integer and vector registers cleared to 0.
  - Instruction memory is not cleared.
- Latency: instruction at address A appears on instr_o one cycle after pc_o = A.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a register read whose index matches a same-cycle enabled write returns the write data (write-through).
- Undefined: the read returns the old contents until the next cycle.

Test Plan:
- Reset check: hold rst_ni = 0 -> pc_o = 0, instr_o = 0, flag_nop_o = 1. Release -> pc_o counts 1, 2, 3 per clock.
- Integer ALU decode: load program with 0x1123 at 0; write R2 = 5, R3 = 7 via writeback -> on instr_o = 0x1123: en_alu_int_o = 1, wr_int_o = 1, alu_op_o = 0, int_dest_o = 1, int_oper1_o = 5, int_oper2_o = 7.
- Vector swap decode: write V1 = 64'h0102030405060708; execute 0xB1A4 -> en_swap_o = 1, vec_oper1_o = V1, swap_src_o = 5, swap_dst_o = 1, vec_dest_o = 1.
- Jump redirect: assert jump_en_i with jump_addr_i = 10'h020 -> next pc_o = 0x0020 and instr_o = 0x0000 for one cycle. Separately, 0xA5FF decodes en_jump_o = 1, cond_o = 1, jump_addr_o = 0x1FF.
- Halt: END 0xF000 at address 3 -> pc_o stops at 4, flag_end_o stays 1. A later jump_en_i to 0 resumes fetch.
- Bypass: int_we_i = 1, int_dest_i = 2, int_wd_i = 0x1234 in the same cycle R2 is read -> int_oper1_o = 0x1234 with RF_BYPASS_EN defined, old value without it.
